// File: rtl/fsb_responder.sv
// fsb_responder: responder end of the single-wire fast serial bus.
// Ports: clk, rst_n, rx_in (pad in), tx_out/tx_oe (pad drive), cycle (bit
// period), rsp_data/rsp_load (response byte), req_data/req_valid, frm_err,
// rsp_done (pulses), busy.
module fsb_responder #(
    parameter int TURN_BITS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        tx_oe,
    input  logic [15:0] cycle,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_load,
    output logic [7:0]  req_data,
    output logic        req_valid,
    output logic        frm_err,
    output logic        rsp_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, RX_START, RX_DATA, RX_STOP,
        TURN, TX_START, TX_DATA, TX_STOP
    } state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic        rx_s, rx_prev_q;
    logic [15:0] pl_q, pl_d;
    logic [19:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  rxsh_q, rxsh_d;
    logic [7:0]  txsh_q, txsh_d;
    logic [7:0]  rsp_q, rsp_d;
    logic        pend_q, pend_d;
    logic [7:0]  req_data_q, req_data_d;
    logic        req_valid_q, req_valid_d;
    logic        frm_err_q, frm_err_d;
    logic        rsp_done_q, rsp_done_d;
    logic        tx_out_q, tx_out_d;
    logic        tx_oe_q, tx_oe_d;

    logic [19:0] pl_ext, cnt_inc, turn_lim;
    logic        bit_end;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign pl_ext   = {4'd0, pl_q};
    assign cnt_inc  = cnt_q + 20'd1;
    // Counter runs 0..Pl-1, so each bit lasts exactly Pl clocks.
    assign bit_end  = (cnt_q == pl_ext - 20'd1);
    assign turn_lim = 20'(TURN_BITS) * pl_ext;

    always_comb begin
        state_d     = state_q;
        pl_d        = pl_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        rxsh_d      = rxsh_q;
        txsh_d      = txsh_q;
        rsp_d       = rsp_q;
        pend_d      = pend_q;
        req_data_d  = req_data_q;
        req_valid_d = 1'b0;
        frm_err_d   = 1'b0;
        rsp_done_d  = 1'b0;
        tx_out_d    = tx_out_q;
        tx_oe_d     = tx_oe_q;
        if (rsp_load) begin
            rsp_d  = rsp_data;
            pend_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (rx_s && !rx_prev_q) begin
                    pl_d    = (cycle < 16'd4) ? 16'd4 : cycle;
                    cnt_d   = '0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == (pl_ext >> 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_DATA : IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    rxsh_d = {rx_s, rxsh_q[7:1]};
                    cnt_d  = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RX_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        req_data_d  = rxsh_q;
                        req_valid_d = 1'b1;
                        state_d     = TURN;
                    end else begin
                        frm_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TURN: begin
                if (cnt_inc >= turn_lim) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        // Send the byte held before this clock; a load in
                        // this same clock stays pending for the next request.
                        txsh_d   = rsp_q;
                        pend_d   = rsp_load;
                        tx_oe_d  = 1'b1;
                        tx_out_d = 1'b1;
                        state_d  = TX_START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    tx_out_d = txsh_q[0];
                    state_d  = TX_DATA;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_out_d = 1'b0;
                        state_d  = TX_STOP;
                    end else begin
                        tx_out_d = txsh_q[1];
                        txsh_d   = {1'b0, txsh_q[7:1]};
                        bit_d    = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cnt_d      = '0;
                    tx_oe_d    = 1'b0;
                    rsp_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            rx_prev_q   <= 1'b0;
            pl_q        <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            rxsh_q      <= '0;
            txsh_q      <= '0;
            rsp_q       <= '0;
            pend_q      <= 1'b0;
            req_data_q  <= '0;
            req_valid_q <= 1'b0;
            frm_err_q   <= 1'b0;
            rsp_done_q  <= 1'b0;
            tx_out_q    <= 1'b0;
            tx_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rx_prev_q   <= rx_s;
            pl_q        <= pl_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            rxsh_q      <= rxsh_d;
            txsh_q      <= txsh_d;
            rsp_q       <= rsp_d;
            pend_q      <= pend_d;
            req_data_q  <= req_data_d;
            req_valid_q <= req_valid_d;
            frm_err_q   <= frm_err_d;
            rsp_done_q  <= rsp_done_d;
            tx_out_q    <= tx_out_d;
            tx_oe_q     <= tx_oe_d;
        end
    end

    assign tx_out    = tx_out_q;
    assign tx_oe     = tx_oe_q;
    assign req_data  = req_data_q;
    assign req_valid = req_valid_q;
    assign frm_err   = frm_err_q;
    assign rsp_done  = rsp_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fsb_responder.sv
// tb_fsb_responder: self-checking bench for fsb_responder.
// Drives request frames on a modelled shared wire and checks pulses/response.
module tb_fsb_responder;
    localparam int TB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_drive = 1'b0;
    logic        rx_in;
    logic        tx_out, tx_oe;
    logic [15:0] cycle = 16'd8;
    logic [7:0]  rsp_data = 8'h00;
    logic        rsp_load = 1'b0;
    logic [7:0]  req_data;
    logic        req_valid, frm_err, rsp_done, busy;

    assign rx_in = tx_oe ? tx_out : rx_drive;

    fsb_responder #(.TURN_BITS(TB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
        .tx_out(tx_out), .tx_oe(tx_oe), .cycle(cycle),
        .rsp_data(rsp_data), .rsp_load(rsp_load),
        .req_data(req_data), .req_valid(req_valid),
        .frm_err(frm_err), .rsp_done(rsp_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    int cyc_n = 0, rv_n = 0, fe_n = 0, rd_n = 0, rv_t = 0, oe_t = 0;
    logic [7:0] rv_data = 8'h00;
    bit oe_prev = 1'b0;
    bit txq[$];

    bit         m_pend = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_req = 8'h00;

    initial forever begin
        @(negedge clk);
        cyc_n++;
        if (rst_n) begin
            if (req_valid) begin
                rv_n++;
                rv_data = req_data;
                rv_t = cyc_n;
            end
            if (frm_err) fe_n++;
            if (rsp_done) rd_n++;
            if (tx_oe) txq.push_back(tx_out);
            if (tx_oe && !oe_prev) oe_t = cyc_n;
        end
        oe_prev = tx_oe;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        rsp_data = b;
        rsp_load = 1'b1;
        wait_clk(1);
        rsp_load = 1'b0;
        m_pend = 1'b1;
        m_byte = b;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p,
                              input bit stop, input bit chg);
        rx_drive = 1'b1;
        wait_clk(p);
        if (chg) cycle = 16'd16;
        for (int i = 0; i < 8; i++) begin
            rx_drive = d[i];
            wait_clk(p);
        end
        rx_drive = stop;
        wait_clk(p);
        rx_drive = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            wait_clk(1);
            k++;
        end
        chk("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic run_txn(input logic [15:0] cyc, input logic [7:0] d,
                           input bit good, input bit chg, input bit exp_rv,
                           input bit exp_tx, input logic [7:0] txb,
                           input bit late, input logic [7:0] late_b);
        int p, rv0, fe0, rd0, nbad;
        bit e;
        rv0 = rv_n;
        fe0 = fe_n;
        rd0 = rd_n;
        txq.delete();
        cycle = cyc;
        p = (cyc < 4) ? 4 : int'(cyc);
        fork
            send_frame(d, p, !good, chg);
            if (late) begin
                int k = 0;
                while (!req_valid && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                repeat (TB * p - 1) @(negedge clk);
                rsp_data = late_b;
                rsp_load = 1'b1;
                @(negedge clk);
                rsp_load = 1'b0;
            end
        join
        wait_idle(40 * p + 50);
        wait_clk(2);
        chk("rv_count", rv_n - rv0, {31'd0, exp_rv});
        chk("fe_count", fe_n - fe0, {31'd0, !good});
        chk("req_data", {24'd0, req_data}, {24'd0, exp_rv ? d : m_req});
        chk("tx_len", txq.size(), exp_tx ? 10 * p : 0);
        chk("rsp_done", rd_n - rd0, {31'd0, exp_tx});
        if (exp_tx) begin
            nbad = 0;
            for (int k = 0; k < txq.size() && k < 10 * p; k++) begin
                if (k < p) e = 1'b1;
                else if (k < 9 * p) e = txb[(k - p) / p];
                else e = 1'b0;
                if (txq[k] != e) nbad++;
            end
            chk("tx_wave_bad_clks", nbad, 0);
            chk("turn_gap", oe_t - rv_t, TB * p);
        end
        if (exp_rv) m_req = d;
        if (exp_tx) m_pend = 1'b0;
        if (late) begin
            m_pend = 1'b1;
            m_byte = late_b;
        end
    endtask

    typedef struct {
        logic [15:0] cyc;
        logic [7:0]  d;
        bit          good;
        bit          ld;
        logic [7:0]  lb;
        bit          chg;
        bit          exp_rv;
        bit          exp_tx;
        logic [7:0]  txb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int k;
        logic [15:0] rc;
        logic [7:0]  rd;
        bit          rg, etx;

        tbl[0] = '{16'd8, 8'h3C, 1, 1, 8'hA5, 0, 1, 1, 8'hA5};
        tbl[1] = '{16'd8, 8'h81, 1, 0, 8'h00, 0, 1, 0, 8'h00};
        tbl[2] = '{16'd8, 8'h55, 0, 1, 8'h77, 0, 0, 0, 8'h00};
        tbl[3] = '{16'd2, 8'h12, 1, 0, 8'h00, 0, 1, 1, 8'h77};
        tbl[4] = '{16'd8, 8'hC3, 1, 1, 8'h5A, 1, 1, 1, 8'h5A};
        tbl[5] = '{16'd0, 8'hF0, 1, 0, 8'h00, 0, 1, 0, 8'h00};

        wait_clk(3);
        chk("rst_tx_oe", {31'd0, tx_oe}, 0);
        chk("rst_tx_out", {31'd0, tx_out}, 0);
        chk("rst_req_data", {24'd0, req_data}, 0);
        chk("rst_pulses", {29'd0, req_valid, frm_err, rsp_done}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        wait_clk(3);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].ld) load(tbl[i].lb);
            run_txn(tbl[i].cyc, tbl[i].d, tbl[i].good, tbl[i].chg,
                    tbl[i].exp_rv, tbl[i].exp_tx, tbl[i].txb, 0, 8'h00);
        end

        load(8'hA1);
        run_txn(16'd8, 8'h44, 1, 0, 1, 1, 8'hA1, 1, 8'hB2);
        run_txn(16'd8, 8'h45, 1, 0, 1, 1, 8'hB2, 0, 8'h00);

        rx_drive = 1'b1;
        wait_clk(2);
        rx_drive = 1'b0;
        k = rv_n + fe_n;
        wait_clk(20);
        chk("glitch_busy", {31'd0, busy}, 0);
        chk("glitch_pulses", rv_n + fe_n, k);
        chk("glitch_req_data", {24'd0, req_data}, {24'd0, m_req});

        load(8'hE7);
        cycle = 16'd8;
        send_frame(8'h99, 8, 1'b0, 1'b0);
        k = 0;
        while (!tx_oe && k < 200) begin
            wait_clk(1);
            k++;
        end
        chk("tx_start_seen", {31'd0, tx_oe}, 1);
        wait_clk(8 + 20);
        rst_n = 1'b0;
        #2;
        chk("arst_tx_oe", {31'd0, tx_oe}, 0);
        chk("arst_tx_out", {31'd0, tx_out}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        wait_clk(2);
        rst_n = 1'b1;
        m_pend = 1'b0;
        m_req = 8'h00;
        wait_clk(2);
        chk("arst_req_data", {24'd0, req_data}, 0);
        run_txn(16'd8, 8'h12, 1, 0, 1, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            rc = 16'($urandom_range(0, 12));
            rd = 8'($urandom);
            rg = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) begin
                load(8'($urandom));
                if ($urandom_range(0, 2) == 0) load(8'($urandom));
            end
            etx = rg && m_pend;
            run_txn(rc, rd, rg, 0, rg, etx, m_byte, 0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
